// File: rtl/detection_collector_if.sv
// Handshake bundle between one processor core, the detection collector and
// the detection readout consumer.
//   master : processor/consumer side (drives result and pop request)
//   slave  : detection_collector side (drives taken and the FIFO head)
interface detection_collector_if #(
  parameter int COORD_W = 10
);
  logic               res_valid;
  logic               res_passfail;
  logic               res_taken;
  logic               det_valid;
  logic [COORD_W-1:0] det_x;
  logic [COORD_W-1:0] det_y;
  logic               det_ready;

  modport master (
    output res_valid, res_passfail, det_ready,
    input  res_taken, det_valid, det_x, det_y
  );

  modport slave (
    input  res_valid, res_passfail, det_ready,
    output res_taken, det_valid, det_x, det_y
  );
endinterface

// File: rtl/detection_collector.sv
// detection_collector: accepts per-window pass/fail results, tracks the
// raster (x,y) of each window, queues passing coordinates in a FWFT FIFO and
// pulses frame_done once the frame is resolved and the FIFO has drained.
// Optional feature macro DETECT_COUNT_EN adds det_count, the saturating
// number of detections pushed in the current frame.
// FIFO_DEPTH must be a power of two and at least 2.
module detection_collector #(
  parameter int COLS       = 16,
  parameter int ROWS       = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int COORD_W    = 10
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   frame_start,
  detection_collector_if.slave   bus,
  output logic                   frame_done,
  output logic                   err_unexp
`ifdef DETECT_COUNT_EN
  ,
  output logic [15:0]            det_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(COLS - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(ROWS - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d;
  logic [COORD_W-1:0]   y_q, y_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 err_q, err_d;
  logic [2*COORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [2*COORD_W-1:0] head;

  logic res_taken;
  logic accept;
  logic push;
  logic pop;
  logic last_pos;

  // Result handshake: only COLLECT takes results; a pass needs FIFO room,
  // judged on the registered full flag so a same-cycle pop never frees a slot.
  always_comb begin
    res_taken = 1'b0;
    if (state_q == S_COLLECT) begin
      res_taken = bus.res_valid & (~bus.res_passfail | ~full_q);
    end
  end

  assign accept   = bus.res_valid & res_taken;
  assign push     = accept & bus.res_passfail;
  assign pop      = ~empty_q & bus.det_ready;
  assign last_pos = (x_q == X_LAST) && (y_q == Y_LAST);

  // Frame FSM next state, raster position, sticky error and frame_done pulse.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    err_d      = err_q;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.res_valid) begin
          err_d = 1'b1;
        end
        if (frame_start) begin
          state_d = S_COLLECT;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (last_pos) begin
            state_d = S_DRAIN;
          end
        end
        // A restart overrides the position update; the accepted result has
        // already been captured at the old x/y by the FIFO write.
        if (frame_start) begin
          err_d   = 1'b1;
          state_d = S_COLLECT;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_DRAIN: begin
        if (bus.res_valid) begin
          err_d = 1'b1;
        end
        if (frame_start) begin
          err_d   = 1'b1;
          state_d = S_COLLECT;
          x_d     = '0;
          y_d     = '0;
        end else if (empty_q) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointer/occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  // Detection storage: written at the current raster position on a push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {x_q, y_q};
    end
  end

  // State, position, FIFO control and error registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      err_q    <= err_d;
    end
  end

  // FWFT head; coordinates forced to 0 while empty so reset shows all zeros.
  assign head          = mem_q[rd_ptr_q];
  assign bus.res_taken = res_taken;
  assign bus.det_valid = ~empty_q;
  assign bus.det_x     = empty_q ? '0 : head[2*COORD_W-1:COORD_W];
  assign bus.det_y     = empty_q ? '0 : head[COORD_W-1:0];
  assign err_unexp     = err_q;

`ifdef DETECT_COUNT_EN
  logic [15:0] det_count_q, det_count_d;

  // Per-frame detection counter, saturating, cleared by every frame_start.
  always_comb begin
    det_count_d = det_count_q;
    if (frame_start) begin
      det_count_d = '0;
    end else if (push && (det_count_q != 16'hFFFF)) begin
      det_count_d = det_count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      det_count_q <= '0;
    end else begin
      det_count_q <= det_count_d;
    end
  end

  assign det_count = det_count_q;
`endif

endmodule

// File: tb/tb_detection_collector.sv
// Bench for detection_collector: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// queue-based frame model.
module tb_detection_collector;
  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 10;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic frame_start = 1'b0;
  logic frame_done;
  logic err_unexp;
`ifdef DETECT_COUNT_EN
  logic [15:0] det_count;
`endif

  detection_collector_if #(.COORD_W(CW)) bus ();

  detection_collector #(
    .COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH), .COORD_W(CW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .frame_start(frame_start),
    .bus(bus),
    .frame_done(frame_done),
    .err_unexp(err_unexp)
`ifdef DETECT_COUNT_EN
    ,
    .det_count(det_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Frame model: phase 0 = idle, 1 = collecting, 2 = waiting for drain.
  int                m_phase = 0;
  int                m_pos   = 0;
  logic [2*CW-1:0]   m_q[$];
  bit                m_err   = 1'b0;
  int                m_cnt   = 0;

  always @(negedge clk) begin : cmp
    bit            e_taken, e_dv, e_done, psh, pp, drained;
    logic [CW-1:0] ex, ey;
    if (!resetn) begin
      m_phase = 0;
      m_pos   = 0;
      m_q.delete();
      m_err   = 1'b0;
      m_cnt   = 0;
    end
    e_taken = (m_phase == 1) && bus.res_valid &&
              (!bus.res_passfail || (m_q.size() < DEPTH));
    e_dv    = (m_q.size() != 0);
    ex      = e_dv ? m_q[0][2*CW-1:CW] : '0;
    ey      = e_dv ? m_q[0][CW-1:0] : '0;
    e_done  = (m_phase == 2) && (m_q.size() == 0) && !frame_start;
    chk("res_taken",  32'(bus.res_taken), 32'(e_taken));
    chk("det_valid",  32'(bus.det_valid), 32'(e_dv));
    chk("det_x",      32'(bus.det_x),     32'(ex));
    chk("det_y",      32'(bus.det_y),     32'(ey));
    chk("frame_done", 32'(frame_done),    32'(e_done));
    chk("err_unexp",  32'(err_unexp),     32'(m_err));
`ifdef DETECT_COUNT_EN
    chk("det_count",  32'(det_count),     32'(m_cnt));
`endif
    if (resetn) begin
      psh     = e_taken && bus.res_passfail;
      pp      = e_dv && bus.det_ready;
      drained = (m_phase == 2) && (m_q.size() == 0);
      if (pp) void'(m_q.pop_front());
      if (psh) m_q.push_back({CW'(m_pos % COLS), CW'(m_pos / COLS)});
      if (m_phase != 1 && bus.res_valid) m_err = 1'b1;
      if (frame_start && m_phase != 0) m_err = 1'b1;
      if (frame_start) m_cnt = 0;
      else if (psh && m_cnt < 65535) m_cnt++;
      if (frame_start) begin
        m_phase = 1;
        m_pos   = 0;
      end else if (m_phase == 1 && e_taken) begin
        if (m_pos == COLS * ROWS - 1) m_phase = 2;
        m_pos++;
      end else if (drained) begin
        m_phase = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit fs, input bit v, input bit pf, input bit rdy);
    frame_start      = fs;
    bus.res_valid    = v;
    bus.res_passfail = pf;
    bus.det_ready    = rdy;
  endtask

  initial begin
    int exp_x[4];
    int exp_y[4];
    exp_x = '{1, 2, 3, 0};
    exp_y = '{0, 0, 0, 1};
    drive(0, 0, 0, 0);
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;

    // T4: result before any frame_start
    step(); drive(0, 1, 1, 0); #2;
    chk("t4_taken_idle", 32'(bus.res_taken), 32'd0);
    step(); drive(0, 0, 0, 0); #2;
    chk("t4_err_set", 32'(err_unexp), 32'd1);

    // T1: 8 results, passes at idx 1 and 6
    step(); drive(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(); drive(0, 1, (i == 1 || i == 6), 1); #2;
      chk("t1_taken", 32'(bus.res_taken), 32'd1);
      if (i == 2) begin
        chk("t1_det0_valid", 32'(bus.det_valid), 32'd1);
        chk("t1_det0_x", 32'(bus.det_x), 32'd1);
        chk("t1_det0_y", 32'(bus.det_y), 32'd0);
      end
      if (i == 7) begin
        chk("t1_det1_valid", 32'(bus.det_valid), 32'd1);
        chk("t1_det1_x", 32'(bus.det_x), 32'd2);
        chk("t1_det1_y", 32'(bus.det_y), 32'd1);
      end
    end
    step(); drive(0, 0, 0, 1); #2;
    chk("t1_frame_done", 32'(frame_done), 32'd1);
    step(); #2;
    chk("t1_frame_done_pulse", 32'(frame_done), 32'd0);
    chk("t4_err_sticky", 32'(err_unexp), 32'd1);

    // T2: back-pressure on a full FIFO
    step(); drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(); drive(0, 1, 1, 0); #2;
      chk("t2_taken", 32'(bus.res_taken), 32'(i < 4));
    end
    step(); drive(0, 1, 1, 1); #2;
    chk("t2_held_on_pop", 32'(bus.res_taken), 32'd0);
    step(); drive(0, 1, 1, 0); #2;
    chk("t2_taken_after_pop", 32'(bus.res_taken), 32'd1);

    // T3: fails while full are still taken and advance the position
    for (int i = 0; i < 3; i++) begin
      step(); drive(0, 1, 0, 0); #2;
      chk("t3_fail_taken", 32'(bus.res_taken), 32'd1);
    end
    for (int k = 0; k < 4; k++) begin
      step(); drive(0, 0, 0, 1); #2;
      chk("t3_head_x", 32'(bus.det_x), 32'(exp_x[k]));
      chk("t3_head_y", 32'(bus.det_y), 32'(exp_y[k]));
    end
    step(); drive(0, 0, 0, 0); #2;
    chk("t3_frame_done", 32'(frame_done), 32'd1);

    // T5: reset mid-COLLECT with 3 entries queued
    step(); drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); drive(0, 1, 1, 0);
    end
    step(); drive(0, 0, 0, 0); #2;
    chk("t5_queued", 32'(bus.det_valid), 32'd1);
    resetn = 1'b0; #1;
    chk("t5_det_valid_rst", 32'(bus.det_valid), 32'd0);
    chk("t5_err_rst", 32'(err_unexp), 32'd0);
    step(); resetn = 1'b1;
    step(); drive(1, 0, 0, 0);
    step(); drive(0, 1, 1, 0);
    step(); drive(0, 0, 0, 0); #2;
    chk("t5_first_x", 32'(bus.det_x), 32'd0);
    chk("t5_first_y", 32'(bus.det_y), 32'd0);

`ifdef DETECT_COUNT_EN
    // T6: per-frame detection count
    step(); drive(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(); drive(0, 1, 1, 1);
    end
    step(); drive(0, 0, 0, 1); #2;
    chk("t6_count5", 32'(det_count), 32'd5);
    step(); drive(1, 0, 0, 1);
    step(); drive(0, 0, 0, 1); #2;
    chk("t6_count_clr", 32'(det_count), 32'd0);
`endif

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      step();
      resetn = ($urandom_range(0, 599) != 0);
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 99) < 65),
            1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 60));
    end
    step(); resetn = 1'b1; drive(0, 0, 0, 1);
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
